keypad_event_decoder: RTL and testbench

- Consumer end of the 16-bit `keys` matrix-state bus produced by the keypad column scanner. Key i = row*4 + column.
- Samples the bus once per full scan, debounces each key and detects press edges.
- Encodes each press into a 4-bit key code and queues it in a small FIFO. The calculator core pops codes with a valid/ready handshake.

---
 rtl/keypad_event_decoder.sv | 139 +++++++++++++
 tb/tb_keypad_event_decoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_decoder.sv
// Keypad event decoder: samples the scanner's key bus once per scan, debounces each key and queues press codes.
// Define KEY_RELEASE_EN to also queue release events with a release flag on each FIFO entry.
module keypad_event_decoder #(
  parameter int SAMPLE_DIV     = 4,
  parameter int DEBOUNCE_COUNT = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keys,
  output logic [3:0]  code,
  output logic        code_valid,
  input  logic        code_ready,
  output logic        code_release,
  output logic [15:0] pressed,
  output logic        overflow,
  input  logic        clear_overflow
);

`ifdef KEY_RELEASE_EN
  localparam int PW = 32;
  localparam int EW = 5;
`else
  localparam int PW = 16;
  localparam int EW = 4;
`endif
  localparam int CW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW  = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [CW-1:0]  SAMP_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0]  DEB_LAST  = DW'(DEBOUNCE_COUNT - 1);
  localparam logic [AW1-1:0] DEPTH     = AW1'(FIFO_DEPTH);

  logic [CW-1:0]  samp_q, samp_d;
  logic           strobe;
  logic [DW-1:0]  cnt_q [16];
  logic [DW-1:0]  cnt_d [16];
  logic [15:0]    pressed_q, pressed_d;
  logic [15:0]    rise;
  logic [PW-1:0]  pending_q, pending_d;
  logic [EW-1:0]  svc_idx;
  logic           svc_valid;
  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW1-1:0] count_q, count_d;
  logic           pop, push, drop;
  logic           overflow_q;

  assign strobe = (samp_q == SAMP_LAST);
  assign samp_d = strobe ? '0 : samp_q + 1'b1;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pressed_d = pressed_q;
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = cnt_q[i];
      if (strobe) begin
        if (keys[i] == pressed_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          pressed_d[i] = ~pressed_q[i];
          cnt_d[i]     = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = pressed_d & ~pressed_q;

  // Descending scan so the lowest set pending bit is the one left in svc_idx.
  always_comb begin
    svc_valid = 1'b0;
    svc_idx   = '0;
    for (int i = PW - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        svc_valid = 1'b1;
        svc_idx   = EW'(i);
      end
    end
  end

  assign code_valid = (count_q != '0);
  assign pop        = code_valid && code_ready;
  assign push       = svc_valid && ((count_q != DEPTH) || pop);
  assign drop       = svc_valid && (count_q == DEPTH) && !pop;
  assign count_d    = count_q + AW1'(push) - AW1'(pop);

  always_comb begin
    pending_d = pending_q;
    if (svc_valid) pending_d[svc_idx] = 1'b0;
    pending_d[15:0] = pending_d[15:0] | rise;
`ifdef KEY_RELEASE_EN
    pending_d[31:16] = pending_d[31:16] | (pressed_q & ~pressed_d);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q     <= '0;
      pressed_q  <= '0;
      pending_q  <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
    end else begin
      samp_q    <= samp_d;
      pressed_q <= pressed_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (drop)                overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= svc_idx;
  end

`ifdef KEY_RELEASE_EN
  assign code         = mem_q[rd_q][3:0];
  assign code_release = mem_q[rd_q][4];
`else
  assign code         = mem_q[rd_q];
  assign code_release = 1'b0;
`endif
  assign pressed  = pressed_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_event_decoder.sv
// Self-checking bench for keypad_event_decoder: vector table, timed corner sequences, random run against a queue model.
module tb_keypad_event_decoder;

  localparam int SD = 4;
  localparam int DC = 3;
  localparam int FD = 4;
`ifdef KEY_RELEASE_EN
  localparam int NPEND = 32;
`else
  localparam int NPEND = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  code;
  logic        code_valid;
  logic        code_ready = 1'b0;
  logic        code_release;
  logic [15:0] pressed;
  logic        overflow;
  logic        clear_overflow = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_event_decoder #(.SAMPLE_DIV(SD), .DEBOUNCE_COUNT(DC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .keys(keys), .code(code), .code_valid(code_valid),
    .code_ready(code_ready), .code_release(code_release), .pressed(pressed),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: snapshot count, per-key run lengths, a set of pending events and a queue of codes.
  int m_phase;
  int m_run [16];
  bit [15:0] m_pressed;
  bit m_pend [NPEND];
  int m_q [$];
  bit m_ovf;

  task automatic model_step();
    int svc;
    if (rst) begin
      m_phase = 0;
      m_pressed = '0;
      m_ovf = 1'b0;
      m_q.delete();
      for (int i = 0; i < 16; i++) m_run[i] = 0;
      for (int i = 0; i < NPEND; i++) m_pend[i] = 1'b0;
      return;
    end
    if (m_q.size() > 0 && code_ready) void'(m_q.pop_front());
    svc = -1;
    for (int i = 0; i < NPEND; i++) begin
      if (m_pend[i]) begin
        svc = i;
        break;
      end
    end
    if (svc >= 0) begin
      m_pend[svc] = 1'b0;
      if (m_q.size() < FD) m_q.push_back(svc);
      else m_ovf = 1'b1;
    end else if (clear_overflow) begin
      m_ovf = 1'b0;
    end
    if (svc >= 0 && m_q.size() <= FD && clear_overflow && m_q.size() > 0 && m_q[m_q.size()-1] == svc)
      m_ovf = m_ovf;
    m_phase = m_phase + 1;
    if (m_phase == SD) begin
      m_phase = 0;
      for (int i = 0; i < 16; i++) begin
        if (keys[i] == m_pressed[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DC) begin
            m_run[i] = 0;
            m_pressed[i] = ~m_pressed[i];
            if (m_pressed[i]) m_pend[i] = 1'b1;
            else if (NPEND > 16) m_pend[(16 + i) % NPEND] = 1'b1;
          end
        end
      end
    end
  endtask

  // Overflow clear only applies on cycles without a drop; recompute that rule explicitly each edge.
  bit m_drop_seen;

  task automatic tick();
    int before_size;
    bit had_pend;
    bit popping;
    before_size = m_q.size();
    popping = (before_size > 0) && code_ready;
    had_pend = 1'b0;
    for (int i = 0; i < NPEND; i++) if (m_pend[i]) had_pend = 1'b1;
    m_drop_seen = !rst && had_pend && (before_size == FD) && !popping;
    model_step();
    if (!rst && !m_drop_seen && clear_overflow) m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    code_ready = 1'b0;
    clear_overflow = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] keys;
    logic [15:0] exp_pressed;
    int          exp_n;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [5];
  int   got [8];
  int   exp_codes [4];
  int   n_got, n_exp, n_ev;

  initial begin
    vecs[0] = '{16'h0020, 16'h0020, 1, 1'b0};
    vecs[1] = '{16'h8421, 16'h8421, 4, 1'b0};
    vecs[2] = '{16'h001F, 16'h001F, 4, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 0, 1'b0};
    vecs[4] = '{16'hC000, 16'hC000, 2, 1'b0};

    do_reset();
    check("reset_valid", code_valid, 1'b0);
    check("reset_pressed", pressed, 16'h0);
    check("reset_overflow", overflow, 1'b0);

    // Vector table: hold a key pattern from reset, then drain the FIFO.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      keys = vecs[v].keys;
      repeat (20) tick();
      check($sformatf("vec%0d_pressed", v), pressed, vecs[v].exp_pressed);
      check($sformatf("vec%0d_overflow", v), overflow, vecs[v].exp_ovf);
      n_exp = 0;
      for (int b = 0; b < 16; b++) begin
        if (vecs[v].keys[b] && n_exp < 4) begin
          exp_codes[n_exp] = b;
          n_exp = n_exp + 1;
        end
      end
      n_got = 0;
      for (int k = 0; k < 8; k++) begin
        if (!code_valid) break;
        got[n_got] = int'(code);
        n_got = n_got + 1;
        code_ready = 1'b1;
        tick();
      end
      code_ready = 1'b0;
      check($sformatf("vec%0d_count", v), n_got, vecs[v].exp_n);
      for (int k = 0; k < n_exp && k < n_got; k++)
        check($sformatf("vec%0d_code%0d", v, k), got[k], exp_codes[k]);
    end

    // Debounced press timing: edge 0 is the first edge with rst low.
    do_reset();
    keys = 16'h0020;
    repeat (11) tick();
    check("press_e10_pressed", pressed, 16'h0000);
    tick();
    check("press_e11_pressed", pressed, 16'h0020);
    check("press_e11_valid", code_valid, 1'b0);
    tick();
    check("press_e12_valid", code_valid, 1'b1);
    check("press_e12_code", code, 4'd5);
    check("press_e12_release", code_release, 1'b0);
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    check("press_popped_valid", code_valid, 1'b0);

    // Bounce: high, high, low, then high; press lands on the 3rd fresh high snapshot (edge 23).
    do_reset();
    keys = 16'h0004;
    repeat (8) tick();
    keys = 16'h0000;
    repeat (4) tick();
    keys = 16'h0004;
    repeat (8) tick();
    check("bounce_e19_pressed", pressed, 16'h0000);
    repeat (4) tick();
    check("bounce_e23_pressed", pressed, 16'h0004);
    code_ready = 1'b1;
    n_ev = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (code_valid) begin
        n_ev = n_ev + 1;
        check("bounce_code", code, 4'd2);
      end
    end
    code_ready = 1'b0;
    check("bounce_events", n_ev, 1);

    // Full FIFO with a pop in the cycle key 4 is serviced.
    do_reset();
    keys = 16'h001F;
    repeat (16) tick();
    check("fullpop_head0", code, 4'd0);
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    check("fullpop_overflow", overflow, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("fullpop_valid%0d", k), code_valid, 1'b1);
      check($sformatf("fullpop_code%0d", k), code, 32'(k));
      code_ready = 1'b1;
      tick();
      code_ready = 1'b0;
    end
    check("fullpop_empty", code_valid, 1'b0);
    check("fullpop_overflow_end", overflow, 1'b0);

    // Drop coinciding with clear: set wins; a later lone clear empties the flag.
    do_reset();
    keys = 16'h001F;
    repeat (16) tick();
    check("ovf_before_drop", overflow, 1'b0);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_set_wins", overflow, 1'b1);
    tick();
    check("ovf_sticky", overflow, 1'b1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // Reset mid-operation: two codes queued, key 7 two snapshots into its debounce.
    do_reset();
    keys = 16'h0003;
    repeat (14) tick();
    check("midrst_queued", code_valid, 1'b1);
    keys = 16'h0083;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check("midrst_valid", code_valid, 1'b0);
    check("midrst_pressed", pressed, 16'h0000);
    check("midrst_overflow", overflow, 1'b0);
    rst = 1'b0;
    repeat (11) tick();
    check("midrst_no_early_press", pressed, 16'h0000);
    check("midrst_no_early_event", code_valid, 1'b0);
    tick();
    check("midrst_fresh_press", pressed, 16'h0083);

    // Release of key 5 after its press.
    do_reset();
    keys = 16'h0020;
    repeat (13) tick();
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    keys = 16'h0000;
    n_ev = 0;
    for (int k = 0; k < 24; k++) begin
      if (code_valid && n_ev == 0) begin
        n_ev = 1;
        check("release_code", code, 4'd5);
        check("release_flag", code_release, 1'b1);
      end
      tick();
    end
`ifdef KEY_RELEASE_EN
    check("release_seen", n_ev, 1);
`else
    check("release_none", n_ev, 0);
`endif
    check("release_pressed", pressed, 16'h0000);

    // Random run compared against the model every cycle.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) keys[$urandom_range(0, 15)] ^= 1'b1;
      code_ready     = ($urandom_range(0, 3) == 0);
      clear_overflow = ($urandom_range(0, 15) == 0);
      rst            = ($urandom_range(0, 799) == 0);
      tick();
      check("rnd_valid", code_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        check("rnd_code", code, m_q[0] % 16);
        check("rnd_release", code_release, m_q[0] / 16);
      end
      check("rnd_pressed", pressed, m_pressed);
      check("rnd_overflow", overflow, m_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
